// File: rtl/dsa_pkg.sv
// dsa_pkg: shared types and memory-map constants for the DSA pipeline
package dsa_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, FLUSH, DONE} loader_state_t;
  localparam logic [15:0] DSA_ADDR_INPUT = 16'd0;
  localparam logic [15:0] DSA_ADDR_OUTPUT = 16'd16384;
  localparam int DSA_INPUT_WORDS = 16384;
  localparam int PIX_PER_WORD = 4;
endpackage

// File: rtl/dsa_byte_packer.sv
// dsa_byte_packer: packs bytes little-endian into 32-bit words with a lane mask
module dsa_byte_packer
  import dsa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic        clear,
  output logic [31:0] word,
  output logic [3:0]  mask,
  output logic        word_ready
);
  logic [1:0]  lane;
  logic [31:0] acc, acc_nxt;
  logic [3:0]  acc_mask, mask_nxt;
  logic        fire;
  assign fire = push && (lane == 2'(PIX_PER_WORD - 1) || last);
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{lane, 3'b000} +: 8] = data;
    mask_nxt = acc_mask | (4'b0001 << lane);
  end
  // a completed word moves to the output register so the accumulator is free next cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane <= '0;
      acc <= '0;
      acc_mask <= '0;
      word <= '0;
      mask <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= fire;
      word <= fire ? acc_nxt : '0;
      mask <= fire ? mask_nxt : '0;
      if (push) begin
        lane <= fire ? '0 : lane + 2'd1;
        acc <= fire ? '0 : acc_nxt;
        acc_mask <= fire ? '0 : mask_nxt;
      end
    end
  end
endmodule

// File: rtl/dsa_pixel_loader.sv
// dsa_pixel_loader: streams 8-bit raster pixels into the shared RAM input region
module dsa_pixel_loader
  import dsa_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DSA_ADDR_INPUT),
  parameter int MAX_WORDS = DSA_INPUT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_img_width,
  input  logic [DIM_W-1:0]  i_img_height,
  input  logic              i_px_valid,
  input  logic [7:0]        i_px_data,
  output logic              o_px_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_byte_en,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [17:0]       o_pix_count
);
  loader_state_t state, nxt;
  logic [DIM_W-1:0]  w, h;
  logic [17:0]       total;
  logic [18:0]       words;
  logic [ADDR_W-1:0] idx;
  logic              start, bad, accept, last;
  assign start = state == IDLE && i_start;
  assign words = ({1'b0, total} + 19'd3) >> 2;
  assign bad = w == '0 || h == '0 || words > 19'(MAX_WORDS);
  assign accept = o_px_ready && i_px_valid;
  assign last = accept && (o_pix_count + 18'd1 == total);
  assign o_mem_addr = BASE_ADDR + idx;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = i_start ? CHECK : IDLE;
      CHECK: nxt = bad ? DONE : LOAD;
      LOAD:  nxt = last ? FLUSH : LOAD;
      FLUSH: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state == CHECK || state == LOAD || state == FLUSH;
    o_px_ready = state == LOAD;
    o_done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w <= '0;
      h <= '0;
      total <= '0;
      idx <= '0;
      o_pix_count <= '0;
      o_error <= 1'b0;
    end else if (start) begin
      w <= i_img_width;
      h <= i_img_height;
      total <= 18'(i_img_width) * 18'(i_img_height);
      idx <= '0;
      o_pix_count <= '0;
      o_error <= 1'b0;
    end else begin
      if (accept) o_pix_count <= o_pix_count + 18'd1;
      if (o_mem_we) idx <= idx + 1'b1;
      if (state == CHECK && bad) o_error <= 1'b1;
    end
  end
  dsa_byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .data(i_px_data),
    .last(last),
    .clear(start),
    .word(o_mem_wdata),
    .mask(o_mem_byte_en),
    .word_ready(o_mem_we)
  );
endmodule

// File: tb/tb_dsa_pixel_loader.sv
// tb_dsa_pixel_loader: directed scenarios for the pixel loader with hand-derived expectations
module tb_dsa_pixel_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [8:0]  i_img_width = '0;
  logic [8:0]  i_img_height = '0;
  logic        i_px_valid = 1'b0;
  logic [7:0]  i_px_data = '0;
  logic        o_px_ready, o_mem_we, o_busy, o_done, o_error;
  logic [15:0] o_mem_addr;
  logic [3:0]  o_mem_byte_en;
  logic [31:0] o_mem_wdata;
  logic [17:0] o_pix_count;
  int vecs = 0, errs = 0;
  int cyc = 0, wc = 0, dc = 0, rc = 0, done_cyc = 0, lastw_cyc = 0;
  logic [15:0] wa [256];
  logic [31:0] wd [256];
  logic [3:0]  wb [256];

  always #5 clk = ~clk;

  dsa_pixel_loader dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_img_width(i_img_width), .i_img_height(i_img_height),
    .i_px_valid(i_px_valid), .i_px_data(i_px_data), .o_px_ready(o_px_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_byte_en(o_mem_byte_en),
    .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_pix_count(o_pix_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: logs every write, done pulse and ready cycle
  always @(negedge clk) begin
    if (o_mem_we) begin
      if (wc < 256) begin
        wa[wc] = o_mem_addr;
        wd[wc] = o_mem_wdata;
        wb[wc] = o_mem_byte_en;
      end
      wc++;
      lastw_cyc = cyc;
    end
    if (o_done) begin
      dc++;
      done_cyc = cyc;
    end
    if (o_px_ready) rc++;
  end

  // expected word k of an n-pixel ramp starting at base
  function automatic logic [31:0] ew(int base, int k, int n);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) if (4 * k + j < n) r[8 * j +: 8] = 8'(base + 4 * k + j);
    return r;
  endfunction

  function automatic logic [3:0] eb(int k, int n);
    logic [3:0] r = '0;
    for (int j = 0; j < 4; j++) if (4 * k + j < n) r[j] = 1'b1;
    return r;
  endfunction

  task automatic run_load(input int w, input int h, input int base, input bit gaps, input bit poke, output int w0);
    int n = w * h;
    int i = 0;
    int k = 0;
    w0 = wc;
    @(negedge clk);
    i_img_width = 9'(w);
    i_img_height = 9'(h);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (i < n && k < 4000) begin
      @(negedge clk);
      k++;
      i_px_valid = !gaps || (k % 4 == 0) || (k % 4 == 3) || ($urandom_range(0, 3) == 0);
      i_px_data = i_px_valid ? 8'(base + i) : 8'hA5;
      i_start = poke && (i == n / 2);
      if (poke) begin
        i_img_width = 9'd2;
        i_img_height = 9'd2;
      end
      if (i_px_valid && o_px_ready) i++;
    end
    vecs++;
    if (k >= 4000) begin
      errs++;
      $display("FAIL stream_timeout: accepted %0d, required %0d", i, n);
    end
    @(negedge clk);
    i_px_valid = 1'b0;
    i_start = poke;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({o_busy, o_px_ready, o_mem_we, o_mem_byte_en, o_mem_wdata, o_done, o_error, o_pix_count, o_mem_addr} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%b rdy=%b we=%b be=%b wd=%h done=%b err=%b cnt=%0d addr=%0d, required all 0",
               o_busy, o_px_ready, o_mem_we, o_mem_byte_en, o_mem_wdata, o_done, o_error, o_pix_count, o_mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_size_error();
    int cfg_w [2] = '{511, 0};
    int cfg_h [2] = '{511, 5};
    for (int c = 0; c < 2; c++) begin
      int w0 = wc, d0 = dc, r0 = rc;
      @(negedge clk);
      i_img_width = 9'(cfg_w[c]);
      i_img_height = 9'(cfg_h[c]);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      vecs++;
      if (o_error !== 1'b1 || o_done !== 1'b1) begin
        errs++;
        $display("FAIL err_after_check[%0d]: error=%b done=%b, required 1 1", c, o_error, o_done);
      end
      repeat (4) @(negedge clk);
      vecs++;
      if (wc - w0 != 0 || dc - d0 != 1 || rc - r0 != 0 || o_error !== 1'b1 || o_busy !== 1'b0) begin
        errs++;
        $display("FAIL err_response[%0d]: writes=%0d dones=%0d ready_cycles=%0d error=%b busy=%b, required 0 1 0 1 0",
                 c, wc - w0, dc - d0, rc - r0, o_error, o_busy);
      end
    end
  endtask

  task automatic test_full_words();
    int w0;
    run_load(8, 4, 32, 1'b0, 1'b0, w0);
    vecs++;
    if (wc - w0 != 8) begin
      errs++;
      $display("FAIL full_write_count: got %0d, required 8", wc - w0);
    end
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (wa[w0 + k] !== 16'(k) || wd[w0 + k] !== ew(32, k, 32) || wb[w0 + k] !== 4'b1111) begin
        errs++;
        $display("FAIL full_word[%0d]: addr=%0d data=%h be=%b, required %0d %h 1111", k, wa[w0 + k], wd[w0 + k], wb[w0 + k], k, ew(32, k, 32));
      end
    end
    vecs++;
    if (wd[w0] !== 32'h23222120 || wd[w0 + 7] !== 32'h3F3E3D3C) begin
      errs++;
      $display("FAIL full_ends: word0=%h word7=%h, required 23222120 3F3E3D3C", wd[w0], wd[w0 + 7]);
    end
    vecs++;
    if (done_cyc != lastw_cyc + 1 || o_pix_count !== 18'd32 || o_error !== 1'b0) begin
      errs++;
      $display("FAIL full_done: done_gap=%0d count=%0d error=%b, required 1 32 0", done_cyc - lastw_cyc, o_pix_count, o_error);
    end
  endtask

  task automatic test_partial_word();
    int w0;
    run_load(5, 3, 0, 1'b0, 1'b0, w0);
    vecs++;
    if (wc - w0 != 4) begin
      errs++;
      $display("FAIL partial_write_count: got %0d, required 4", wc - w0);
    end
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (wa[w0 + k] !== 16'(k) || wd[w0 + k] !== ew(0, k, 15) || wb[w0 + k] !== eb(k, 15)) begin
        errs++;
        $display("FAIL partial_word[%0d]: addr=%0d data=%h be=%b, required %0d %h %b", k, wa[w0 + k], wd[w0 + k], wb[w0 + k], k, ew(0, k, 15), eb(k, 15));
      end
    end
    vecs++;
    if (wd[w0 + 3] !== 32'h000E0D0C || wb[w0 + 3] !== 4'b0111) begin
      errs++;
      $display("FAIL partial_last: data=%h be=%b, required 000E0D0C 0111", wd[w0 + 3], wb[w0 + 3]);
    end
  endtask

  task automatic test_valid_gaps();
    int w0;
    run_load(8, 4, 32, 1'b1, 1'b0, w0);
    vecs++;
    if (wc - w0 != 8) begin
      errs++;
      $display("FAIL gaps_write_count: got %0d, required 8", wc - w0);
    end
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (wa[w0 + k] !== 16'(k) || wd[w0 + k] !== ew(32, k, 32) || wb[w0 + k] !== 4'b1111) begin
        errs++;
        $display("FAIL gaps_word[%0d]: addr=%0d data=%h be=%b, required %0d %h 1111", k, wa[w0 + k], wd[w0 + k], wb[w0 + k], k, ew(32, k, 32));
      end
    end
  endtask

  task automatic test_abort();
    int w0 = wc, i = 0, k = 0, f0;
    @(negedge clk);
    i_img_width = 9'd8;
    i_img_height = 9'd4;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (i < 10 && k < 100) begin
      @(negedge clk);
      k++;
      i_px_valid = 1'b1;
      i_px_data = 8'(i);
      if (o_px_ready) i++;
    end
    @(negedge clk);
    rst = 1'b1;
    i_px_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({o_busy, o_px_ready, o_mem_we, o_mem_byte_en, o_mem_wdata, o_done, o_error, o_pix_count, o_mem_addr} !== '0) begin
      errs++;
      $display("FAIL abort_outputs: busy=%b rdy=%b we=%b be=%b wd=%h cnt=%0d addr=%0d, required all 0",
               o_busy, o_px_ready, o_mem_we, o_mem_byte_en, o_mem_wdata, o_pix_count, o_mem_addr);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (wc - w0 != 2 || wa[w0] !== 16'd0 || wa[w0 + 1] !== 16'd1 || wd[w0 + 1] !== 32'h07060504) begin
      errs++;
      $display("FAIL abort_writes: count=%0d addr0=%0d addr1=%0d data1=%h, required 2 0 1 07060504", wc - w0, wa[w0], wa[w0 + 1], wd[w0 + 1]);
    end
    run_load(8, 4, 32, 1'b0, 1'b0, f0);
    vecs++;
    if (wc - f0 != 8 || wd[f0] !== 32'h23222120 || wd[f0 + 7] !== 32'h3F3E3D3C || wa[f0 + 7] !== 16'd7) begin
      errs++;
      $display("FAIL abort_reload: writes=%0d word0=%h word7=%h addr7=%0d, required 8 23222120 3F3E3D3C 7", wc - f0, wd[f0], wd[f0 + 7], wa[f0 + 7]);
    end
  endtask

  task automatic test_start_ignored();
    int w0, d0 = dc;
    run_load(8, 4, 32, 1'b0, 1'b1, w0);
    vecs++;
    if (wc - w0 != 8 || dc - d0 != 1 || o_pix_count !== 18'd32 || o_busy !== 1'b0) begin
      errs++;
      $display("FAIL start_ignored: writes=%0d dones=%0d count=%0d busy=%b, required 8 1 32 0", wc - w0, dc - d0, o_pix_count, o_busy);
    end
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (wa[w0 + k] !== 16'(k) || wd[w0 + k] !== ew(32, k, 32)) begin
        errs++;
        $display("FAIL start_ignored_word[%0d]: addr=%0d data=%h, required %0d %h", k, wa[w0 + k], wd[w0 + k], k, ew(32, k, 32));
      end
    end
  endtask

  initial begin
    test_reset();
    test_size_error();
    test_full_words();
    test_partial_word();
    test_valid_gaps();
    test_abort();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
